// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and validity check
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade register with load, increment and decrement
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_min
);

  assign at_max = (q == BCD_MAX);
  assign at_min = (q == BCD_MIN);

  // Invalid load digits become 0 so q never leaves 0..9.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= BCD_MIN;
    end else if (ld) begin
      q <= bcd_valid(ld_val) ? ld_val : BCD_MIN;
    end else if (inc) begin
      q <= at_max ? BCD_MIN : q + 4'd1;
    end else if (dec) begin
      q <= at_min ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - cascaded multi-digit BCD up/down counter with wrap or saturate
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  carry,
  output logic                  load_err
);

  localparam logic SATURATE = (WRAP == 0) ? 1'b1 : 1'b0;

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] max_pre;
  logic [DIGITS-1:0] min_pre;
  logic [DIGITS-1:0] bad;
  logic              count;
  logic              terminal;
  logic              step_up;
  logic              step_dn;

  assign count    = en & ~load;
  assign terminal = up ? (&at_max) : (&at_min);
  assign tc       = count & terminal;
  assign step_up  = count & up & ~(SATURATE & terminal);
  assign step_dn  = count & ~up & ~(SATURATE & terminal);

  // Digit i moves only when every lower digit is about to roll over.
  always_comb begin
    max_pre    = '0;
    min_pre    = '0;
    max_pre[0] = 1'b1;
    min_pre[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      max_pre[i] = max_pre[i-1] & at_max[i-1];
      min_pre[i] = min_pre[i-1] & at_min[i-1];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign bad[i] = ~bcd_valid(load_value[4*i +: 4]);

    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .inc    (step_up & max_pre[i]),
      .dec    (step_dn & min_pre[i]),
      .ld     (load),
      .ld_val (load_value[4*i +: 4]),
      .q      (q[4*i +: 4]),
      .at_max (at_max[i]),
      .at_min (at_min[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= tc;
      load_err <= load & (|bad);
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - wrap and saturate instances checked against a decimal integer model
module tb_bcd_counter;

  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, up, load;
  logic [15:0] load_value;
  logic [15:0] q_w, q_s;
  logic        tc_w, tc_s, carry_w, carry_s, le_w, le_s;

  int vectors = 0;
  int miscompares = 0;

  int mv_w = 0, mv_s = 0;
  bit mc_w = 0, mc_s = 0, mle = 0;

  always #5 clk = ~clk;

  bcd_counter #(.DIGITS(4), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
    .q(q_w), .tc(tc_w), .carry(carry_w), .load_err(le_w)
  );

  bcd_counter #(.DIGITS(4), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
    .q(q_s), .tc(tc_s), .carry(carry_s), .load_err(le_s)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal model: integer value, invalid digits counted as 0 on load.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mv_w = 0; mv_s = 0; mc_w = 0; mc_s = 0; mle = 0;
    end else begin
      mc_w = 0; mc_s = 0; mle = 0;
      if (load) begin
        int v, p, d;
        v = 0; p = 1;
        for (int i = 0; i < 4; i++) begin
          d = int'(load_value[4*i +: 4]);
          if (d > 9) begin mle = 1; d = 0; end
          v += d * p;
          p *= 10;
        end
        mv_w = v; mv_s = v;
      end else if (en) begin
        if (up) begin
          if (mv_w == MAXV) begin mv_w = 0; mc_w = 1; end else mv_w++;
          if (mv_s == MAXV) mc_s = 1; else mv_s++;
        end else begin
          if (mv_w == 0) begin mv_w = MAXV; mc_w = 1; end else mv_w--;
          if (mv_s == 0) mc_s = 1; else mv_s--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("q_wrap", q_w, to_bcd(mv_w));
      chk("q_sat", q_s, to_bcd(mv_s));
      chk("carry_wrap", carry_w, mc_w);
      chk("carry_sat", carry_s, mc_s);
      chk("load_err_wrap", le_w, mle);
      chk("load_err_sat", le_s, mle);
    end
  end

  task automatic step(input logic e, input logic u, input logic l, input logic [15:0] lv);
    @(negedge clk);
    en = e; up = u; load = l; load_value = lv;
    #1;
    chk("tc_wrap", tc_w, e & ~l & (u ? (mv_w == MAXV) : (mv_w == 0)));
    chk("tc_sat", tc_s, e & ~l & (u ? (mv_s == MAXV) : (mv_s == 0)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] dir_tab [12];
    dir_tab = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10,
                2'b11, 2'b10, 2'b11, 2'b11};
    reset = 1'b0; en = 0; up = 1; load = 0; load_value = '0;
    #2;
    chk("reset_q", q_w, 16'h0000);
    chk("reset_carry", carry_w, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    step(0, 1, 1, 16'h1234);
    step(1, 1, 0, 16'h0000);
    chk("pre_reset_q", q_w, 16'h1235);
    en = 0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_q_w", q_w, 16'h0000);
    chk("async_reset_q_s", q_s, 16'h0000);
    chk("async_reset_carry", carry_w, 1'b0);
    chk("async_reset_load_err", le_w, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 1, 0, 16'h0000);
    chk("first_count", q_w, 16'h0001);

    step(0, 1, 1, 16'h9998);
    step(1, 1, 0, 16'h0000);
    chk("up_9999", q_w, 16'h9999);
    chk("up_9999_carry", carry_w, 1'b0);
    step(1, 1, 0, 16'h0000);
    chk("wrap_0000", q_w, 16'h0000);
    chk("wrap_carry", carry_w, 1'b1);
    chk("sat_hold1", q_s, 16'h9999);
    chk("sat_carry1", carry_s, 1'b1);
    step(1, 1, 0, 16'h0000);
    chk("wrap_0001", q_w, 16'h0001);
    chk("wrap_carry_drop", carry_w, 1'b0);
    chk("sat_hold2", q_s, 16'h9999);
    chk("sat_carry2", carry_s, 1'b1);

    step(0, 0, 1, 16'h1000);
    step(1, 0, 0, 16'h0000);
    chk("borrow_0999", q_w, 16'h0999);
    step(0, 0, 1, 16'h0000);
    step(1, 0, 0, 16'h0000);
    chk("down_wrap", q_w, 16'h9999);
    chk("down_wrap_carry", carry_w, 1'b1);
    chk("down_sat", q_s, 16'h0000);
    chk("down_sat_carry", carry_s, 1'b1);
    step(0, 0, 0, 16'h0000);
    chk("hold_carry", carry_w, 1'b0);

    step(0, 1, 1, 16'h3C5F);
    chk("bad_load_q", q_w, 16'h3050);
    chk("bad_load_err", le_w, 1'b1);
    step(0, 1, 1, 16'h0042);
    chk("good_load_q", q_w, 16'h0042);
    chk("good_load_err", le_w, 1'b0);

    step(0, 1, 1, 16'h9999);
    step(1, 1, 1, 16'h0007);
    chk("prio_q", q_w, 16'h0007);
    chk("prio_carry", carry_w, 1'b0);

    step(0, 1, 1, 16'h0998);
    foreach (dir_tab[i]) step(dir_tab[i][1], dir_tab[i][0], 0, 16'h0000);
    step(0, 0, 1, 16'h0100);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0000);
    chk("multi_borrow", q_w, 16'h0097);

    step(0, 0, 0, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_counter.md
# bcd_counter

Parametrised multi-digit BCD up/down counter, successor to the single-digit decade counter in the display/timekeeping path. Counts in decimal across `DIGITS` cascaded BCD digits, supports synchronous parallel load, count enable, up/down direction and wrap or saturate mode. It produces a registered carry/borrow pulse for chaining to the next counter stage, and a combinational terminal-count flag for same-cycle cascading.

## Interface
- `DIGITS`, default 4: number of BCD digits, 1..8.
- `WRAP`, default 1: 1 means wrap at the limits; 0 means saturate at the limits.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset. All state is cleared while low.
- `en` input, 1 bit: count enable.
- `up` input, 1 bit: direction. 1 counts up, 0 counts down.
- `load` input, 1 bit: synchronous parallel load.
- `load_value` input, 4·DIGITS bits: BCD value to load. Digit 0 is the LSBs.
- `q` output, 4·DIGITS bits: current BCD count. Digit 0 is the LSBs.
- `tc` output, 1 bit: combinational terminal count. It is `en & ~load & (up ? q==all-9s : q==0)`.
- `carry` output, 1 bit: registered one-cycle carry/borrow pulse.
- `load_err` output, 1 bit: registered one-cycle pulse flagging an invalid load digit.

## Operation
Priority at each rising edge is reset, then load, then en, then hold.

Reset (`reset`=0, asynchronous):
- `q` is cleared to 0.
- `carry` and `load_err` are cleared to 0.

Load (`load`=1):
- Each digit of `load_value` in 0..9 is loaded as given.
- Any digit greater than 9 is loaded as 0, and `load_err` is set to 1 for the next cycle.
- `en` and `up` are ignored.
- `carry` is 0 for the next cycle.

Count (`en`=1, `load`=0, up):
- Digit 0 increments.
- A digit at 9 goes to 0 and carries into the next digit.
- At all 9s:
  - With `WRAP`=1, `q` becomes 0 and `carry`=1 for the next cycle.
  - With `WRAP`=0, `q` holds at all 9s and `carry`=1 for the next cycle, flagging an overflow attempt.

Count (`en`=1, `load`=0, down):
- Digit 0 decrements.
- A digit at 0 goes to 9 and borrows from the next digit.
- At 0:
  - With `WRAP`=1, `q` becomes all 9s and `carry`=1 for the next cycle.
  - With `WRAP`=0, `q` holds at 0 and `carry`=1 for the next cycle.

Hold (`en`=0, `load`=0):
- `q` is unchanged.
- `carry`=0 and `load_err`=0 for the next cycle.

Pulse rules:
- `carry` and `load_err` are never high for more than one cycle per triggering edge.
- Back-to-back triggering edges give back-to-back high cycles.

Direction:
- `up` may change on any cycle.
- Only the value sampled at the edge matters.
- There is no direction-change latency.

Width rule: every digit of `q` is always in 0..9. No non-BCD value is ever observable on `q`.

## Timing
- `q`, `carry` and `load_err` are registered. The update is visible 1 cycle after the sampling edge.
- `tc` is combinational from `q`, `en`, `up` and `load`.
  - `tc` is high in exactly the cycle whose edge produces `carry`.
  - A downstream stage may use `tc` as its `en` for zero-latency cascading.
- Reset assertion mid-count clears outputs immediately, without waiting for a clock.
- Reset deassertion takes effect on the next rising edge. The first edge after deassertion with `en`=1 moves `q` from 0 to 1 (up).
- Load and count on the same edge: load wins, and no `carry` is produced.
- Load with `en`=1 at the terminal value: load wins, and `tc` is 0 in that cycle.

## Structure
- Shared package `bcd_pkg` holds:
  - typedef `bcd_digit_t` (logic [3:0]);
  - constants `BCD_MAX` = 4'd9 and `BCD_MIN` = 4'd0;
  - function `bcd_valid(digit)`.
- Sub-module `bcd_digit`:
  - one digit register with inputs `inc`, `dec`, `ld`, `ld_val`;
  - ripple outputs `at_max` and `at_min`.
- The top level instantiates `DIGITS` copies of `bcd_digit` via generate. It builds the carry/borrow enable chain from the `at_max`/`at_min` AND-prefix, and contains the saturate logic, `tc`, and the `carry`/`load_err` registers.

## Test plan
All scenarios use `DIGITS`=4.
- Reset: assert `reset`=0 mid-count at `q`=0x1234 -> `q`=0x0000, `carry`=0, `load_err`=0 immediately, before the next clock edge.
- Up wrap (`WRAP`=1): load 0x9998, then `en`=1, `up`=1 for 3 edges -> `q` = 0x9999, 0x0000, 0x0001. `tc`=1 only while `q`=0x9999. `carry`=1 only in the cycle with `q`=0x0000.
- Down borrow (`WRAP`=1): load 0x1000, then `up`=0 for 1 edge -> `q`=0x0999. Continuing from 0x0000, one more edge -> `q`=0x9999 and `carry`=1 for one cycle.
- Saturate (`WRAP`=0): at `q`=0x9999 with `up`=1, 2 edges -> `q` stays 0x9999 and `carry`=1 for 2 consecutive cycles. At 0x0000 with `up`=0 -> `q` stays 0x0000.
- Invalid load: `load_value`=0x3C5F -> `q`=0x3050 and `load_err`=1 for exactly one cycle. Then load 0x0042 -> `load_err`=0.
- Priority: `load`=1 with `en`=1 at `q`=0x9999, `load_value`=0x0007 -> `q`=0x0007, `carry`=0, and `tc`=0 in the load cycle.
